// File: rtl/multi_channel_pulse_generator.sv
// CHANNELS independent pulse/PWM generators with a shared enable. Period, width and mode
// are captured into shadow registers on trigger and at each continuous-mode period boundary.
module multi_channel_pulse_generator #(
  parameter int N        = 8,
  parameter int CHANNELS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [CHANNELS*N-1:0] period,
  input  logic [CHANNELS*N-1:0] width,
  input  logic [CHANNELS*2-1:0] mode,
  input  logic [CHANNELS-1:0]   trig,
  input  logic [CHANNELS-1:0]   stop,
  output logic [CHANNELS-1:0]   out,
  output logic [CHANNELS-1:0]   wrap,
  output logic [CHANNELS-1:0]   busy
);

  // Handshake: none. trig/stop are level requests sampled on every rising clk edge;
  // they only take effect while ena is high. busy is the per-channel state (RUN = 1).
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] M_CONT = 2'b01;
  localparam logic [1:0] M_ONE  = 2'b10;

  state_t     state_q [CHANNELS];
  state_t     state_d [CHANNELS];
  logic [N-1:0] count_q [CHANNELS];
  logic [N-1:0] count_d [CHANNELS];
  logic [N-1:0] p_s_q   [CHANNELS];
  logic [N-1:0] p_s_d   [CHANNELS];
  logic [N-1:0] w_s_q   [CHANNELS];
  logic [N-1:0] w_s_d   [CHANNELS];
  logic [1:0]   m_s_q   [CHANNELS];
  logic [1:0]   m_s_d   [CHANNELS];

  logic [N-1:0] live_p  [CHANNELS];
  logic [N-1:0] live_w  [CHANNELS];
  logic [1:0]   live_m  [CHANNELS];
  logic         live_ok [CHANNELS];
  logic         at_wrap [CHANNELS];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      live_p[c]  = period[c*N +: N];
      live_w[c]  = width[c*N +: N];
      live_m[c]  = mode[c*2 +: 2];
      live_ok[c] = (live_p[c] != '0) && ((live_m[c] == M_CONT) || (live_m[c] == M_ONE));
      // p_s is never zero in RUN, so the subtraction cannot underflow where it matters.
      at_wrap[c] = (count_q[c] == (p_s_q[c] - N'(1)));
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      count_d[c] = count_q[c];
      p_s_d[c]   = p_s_q[c];
      w_s_d[c]   = w_s_q[c];
      m_s_d[c]   = m_s_q[c];
      if (ena) begin
        if (stop[c]) begin
          state_d[c] = IDLE;
          count_d[c] = '0;
        end else if (trig[c] && live_ok[c]) begin
          state_d[c] = RUN;
          count_d[c] = '0;
          p_s_d[c]   = live_p[c];
          w_s_d[c]   = live_w[c];
          m_s_d[c]   = live_m[c];
        end else if (state_q[c] == RUN) begin
          if (at_wrap[c]) begin
            count_d[c] = '0;
            if (m_s_q[c] == M_CONT && live_ok[c]) begin
              p_s_d[c] = live_p[c];
              w_s_d[c] = live_w[c];
              m_s_d[c] = live_m[c];
            end else begin
              state_d[c] = IDLE;
            end
          end else begin
            count_d[c] = count_q[c] + N'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (rst) begin
        state_q[c] <= IDLE;
        count_q[c] <= '0;
        p_s_q[c]   <= '0;
        w_s_q[c]   <= '0;
        m_s_q[c]   <= '0;
      end else begin
        state_q[c] <= state_d[c];
        count_q[c] <= count_d[c];
        p_s_q[c]   <= p_s_d[c];
        w_s_q[c]   <= w_s_d[c];
        m_s_q[c]   <= m_s_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      busy[c] = (state_q[c] == RUN);
      out[c]  = busy[c] && ena && (count_q[c] < w_s_q[c]);
      wrap[c] = busy[c] && ena && at_wrap[c];
    end
  end

endmodule

// File: tb/tb_multi_channel_pulse_generator.sv
// Directed bench: a per-cycle vector table on channel 0, then hand sequences for one-shot,
// mid-period update, full-range period, channel independence and reset mid-run.
module tb_multi_channel_pulse_generator;
  localparam int N  = 8;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            ena;
  logic [CH*N-1:0] period;
  logic [CH*N-1:0] width;
  logic [CH*2-1:0] mode;
  logic [CH-1:0]   trig;
  logic [CH-1:0]   stop;
  logic [CH-1:0]   out;
  logic [CH-1:0]   wrap;
  logic [CH-1:0]   busy;

  int n_pass  = 0;
  int n_total = 0;

  multi_channel_pulse_generator #(.N(N), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .period(period), .width(width), .mode(mode),
    .trig(trig), .stop(stop), .out(out), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       trig;
    logic       stop;
    logic       ena;
    logic [7:0] p;
    logic [7:0] w;
    logic [1:0] m;
    logic       exp_out;
    logic       exp_wrap;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [34];

  function automatic vec_t mk(input logic t, input logic s, input logic e, input int p,
                              input int w, input int m, input logic o, input logic wr,
                              input logic b);
    vec_t v;
    v.trig = t; v.stop = s; v.ena = e;
    v.p = 8'(p); v.w = 8'(w); v.m = 2'(m);
    v.exp_out = o; v.exp_wrap = wr; v.exp_busy = b;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_ch(input int c, input int p, input int w, input int m);
    period[c*N +: N] = 8'(p);
    width[c*N +: N]  = 8'(w);
    mode[c*2 +: 2]   = 2'(m);
  endtask

  task automatic stop_all();
    mode = '0;
    stop = '1;
    tick();
    stop = '0;
  endtask

  initial begin
    // channel 0 vectors: inputs held for one edge, outputs expected just after that edge
    tbl[0]  = mk(1, 0, 1, 5, 2, 1, 1, 0, 1);
    tbl[1]  = mk(0, 0, 1, 5, 2, 1, 1, 0, 1);
    tbl[2]  = mk(0, 0, 1, 5, 2, 1, 0, 0, 1);
    tbl[3]  = mk(0, 0, 1, 5, 2, 1, 0, 0, 1);
    tbl[4]  = mk(0, 0, 1, 5, 2, 1, 0, 1, 1);
    tbl[5]  = mk(0, 0, 1, 5, 2, 1, 1, 0, 1);
    tbl[6]  = mk(0, 0, 1, 5, 2, 1, 1, 0, 1);
    tbl[7]  = mk(1, 1, 0, 5, 2, 1, 0, 0, 1);  // ena low: trig/stop ignored, count held
    tbl[8]  = mk(0, 0, 0, 5, 2, 1, 0, 0, 1);
    tbl[9]  = mk(0, 0, 1, 5, 2, 1, 0, 0, 1);
    tbl[10] = mk(0, 0, 1, 5, 2, 1, 0, 0, 1);
    tbl[11] = mk(0, 0, 1, 5, 2, 1, 0, 1, 1);
    tbl[12] = mk(1, 1, 1, 5, 2, 1, 0, 0, 0);  // stop beats trig
    tbl[13] = mk(1, 0, 1, 0, 2, 1, 0, 0, 0);  // P=0 rejected
    tbl[14] = mk(1, 0, 1, 5, 2, 3, 0, 0, 0);  // reserved mode rejected
    tbl[15] = mk(1, 0, 1, 3, 9, 1, 1, 0, 1);  // W >= P
    tbl[16] = mk(0, 0, 1, 3, 9, 1, 1, 0, 1);
    tbl[17] = mk(0, 0, 1, 3, 9, 1, 1, 1, 1);
    tbl[18] = mk(0, 0, 1, 3, 9, 1, 1, 0, 1);
    tbl[19] = mk(0, 0, 1, 3, 9, 1, 1, 0, 1);
    tbl[20] = mk(1, 0, 1, 4, 1, 1, 1, 0, 1);  // retrigger mid-period
    tbl[21] = mk(0, 0, 1, 4, 1, 1, 0, 0, 1);
    tbl[22] = mk(0, 0, 1, 4, 1, 1, 0, 0, 1);
    tbl[23] = mk(0, 0, 1, 4, 1, 1, 0, 1, 1);
    tbl[24] = mk(0, 0, 1, 4, 1, 1, 1, 0, 1);
    tbl[25] = mk(0, 1, 1, 4, 1, 1, 0, 0, 0);
    tbl[26] = mk(1, 0, 1, 1, 1, 2, 1, 1, 1);  // P=1 one-shot
    tbl[27] = mk(0, 0, 1, 1, 1, 2, 0, 0, 0);
    tbl[28] = mk(1, 0, 1, 1, 1, 1, 1, 1, 1);  // P=1 continuous
    tbl[29] = mk(0, 0, 1, 1, 1, 1, 1, 1, 1);
    tbl[30] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0);  // live mode off at boundary
    tbl[31] = mk(1, 0, 1, 2, 0, 1, 0, 0, 1);  // W=0
    tbl[32] = mk(0, 0, 1, 2, 0, 1, 0, 1, 1);
    tbl[33] = mk(0, 1, 1, 2, 0, 1, 0, 0, 0);

    rst = 1'b1; ena = 1'b1; period = '0; width = '0; mode = '0; trig = '0; stop = '0;
    tick();
    trig = '1; stop = '1; set_ch(0, 5, 2, 1);
    tick();
    chk("reset_out", 32'(out), 0);
    chk("reset_wrap", 32'(wrap), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 1'b0; trig = '0; stop = '0; mode = '0;
    tick();

    for (int i = 0; i < 34; i++) begin
      trig[0] = tbl[i].trig;
      stop[0] = tbl[i].stop;
      ena     = tbl[i].ena;
      set_ch(0, int'(tbl[i].p), int'(tbl[i].w), int'(tbl[i].m));
      tick();
      chk($sformatf("vec%0d_out", i),  32'(out[0]),  32'(tbl[i].exp_out));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap[0]), 32'(tbl[i].exp_wrap));
      chk($sformatf("vec%0d_busy", i), 32'(busy[0]), 32'(tbl[i].exp_busy));
    end
    trig = '0; stop = '0; ena = 1'b1;
    stop_all();

    // one-shot on channel 1: P=4, W=1
    set_ch(1, 4, 1, 2);
    trig[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      trig = '0;
      chk($sformatf("oneshot%0d_out", i),  32'(out[1]),  32'(i == 0));
      chk($sformatf("oneshot%0d_wrap", i), 32'(wrap[1]), 32'(i == 3));
      chk($sformatf("oneshot%0d_busy", i), 32'(busy[1]), 32'(i < 4));
    end
    stop_all();

    // mid-period update on channel 2: P=8/W=4, changed to P=4/W=1 at count 2
    set_ch(2, 8, 4, 1);
    trig[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int eo, ew;
      tick();
      trig = '0;
      if (i < 8) begin
        eo = int'(i < 4); ew = int'(i == 7);
      end else begin
        eo = int'(((i - 8) % 4) == 0); ew = int'(((i - 8) % 4) == 3);
      end
      chk($sformatf("update%0d_out", i),  32'(out[2]),  32'(eo));
      chk($sformatf("update%0d_wrap", i), 32'(wrap[2]), 32'(ew));
      if (i == 2) set_ch(2, 4, 1, 1);
    end
    stop_all();

    // full-range period on channel 3: P=255, W=128
    set_ch(3, 255, 128, 1);
    trig[3] = 1'b1;
    for (int i = 0; i < 257; i++) begin
      tick();
      trig = '0;
      chk($sformatf("p255_%0d_out", i),  32'(out[3]),  32'((i % 255) < 128));
      chk($sformatf("p255_%0d_wrap", i), 32'(wrap[3]), 32'((i % 255) == 254));
    end
    stop_all();

    // independence: P = 3,4,5,6 triggered together, all wraps align at cycle 60
    for (int c = 0; c < CH; c++) set_ch(c, 3 + c, 1, 1);
    trig = '1;
    for (int i = 0; i < 61; i++) begin
      tick();
      trig = '0;
      for (int c = 0; c < CH; c++)
        chk($sformatf("indep%0d_ch%0d_wrap", i, c), 32'(wrap[c]), 32'((i % (3 + c)) == (2 + c)));
      if (i == 59) chk("indep_lcm_all_wrap", 32'(wrap), 32'hF);
    end
    chk("indep_busy", 32'(busy), 32'hF);

    // reset mid-run overrides everything
    rst = 1'b1; trig = '1;
    tick();
    chk("rst_mid_out", 32'(out), 0);
    chk("rst_mid_wrap", 32'(wrap), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    rst = 1'b0; trig = '0;
    tick();
    chk("post_rst_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
